// File: rtl/trap_seq.sv
// trap_seq: multicycle sequencer for trap/CP0 instructions (syscall, break, teq, eret, mfc0, mtc0).
// Latency: start to done is 4 cycles when a CP0 write fires, 2 cycles otherwise.
// Backpressure: none; start is dropped while busy, with no queueing.
module trap_seq #(
  parameter int unsigned PC_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] cp0_rdata,
  input  logic [31:0] exc_addr,
  input  logic [31:0] status,
  output logic        cp0_ena,
  output logic        cp0_mfc0,
  output logic        cp0_mtc0,
  output logic        cp0_exception,
  output logic        cp0_eret,
  output logic [4:0]  cp0_cause,
  output logic [4:0]  cp0_addr,
  output logic [31:0] cp0_pc,
  output logic [31:0] cp0_wdata,
  output logic        pc_we,
  output logic [31:0] pc_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FIRE,
    S_SETTLE,
    S_COMMIT
  } state_t;

  typedef enum logic [2:0] {
    K_ILL,
    K_SYSCALL,
    K_BREAK,
    K_TEQ,
    K_ERET,
    K_MFC0,
    K_MTC0
  } kind_t;

  localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
  localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
  localparam logic [4:0] CAUSE_TEQ     = 5'b01101;

  // Classify an instruction word by opcode, rs field and funct field.
  function automatic kind_t decode(input logic [31:0] w);
    kind_t k;
    k = K_ILL;
    if (w[31:26] == 6'h00) begin
      case (w[5:0])
        6'h0C:   k = K_SYSCALL;
        6'h0D:   k = K_BREAK;
        6'h34:   k = K_TEQ;
        default: k = K_ILL;
      endcase
    end else if (w[31:26] == 6'h10) begin
      if (w[25:21] == 5'h10 && w[5:0] == 6'h18) k = K_ERET;
      else if (w[25:21] == 5'h00)               k = K_MFC0;
      else if (w[25:21] == 5'h04)               k = K_MTC0;
      else                                      k = K_ILL;
    end
    return k;
  endfunction

  // Exception cause code carried to CP0 for each trapping instruction.
  function automatic logic [4:0] cause_of(input kind_t k);
    logic [4:0] c;
    case (k)
      K_SYSCALL: c = CAUSE_SYSCALL;
      K_BREAK:   c = CAUSE_BREAK;
      K_TEQ:     c = CAUSE_TEQ;
      default:   c = 5'b00000;
    endcase
    return c;
  endfunction

  state_t      state;
  kind_t       kind_q;
  logic        eq_q;
  logic [31:0] pc_q;
  logic [4:0]  rt_idx_q;

  kind_t       in_kind;
  logic        in_trap;
  logic        cp0_write_req;
  logic        go_fire;
  logic        go_commit;
  logic        redirect;
  logic [31:0] commit_pc;

  // Status bits above bit 0 and the shamt field never influence the sequence.
  logic unused_bits;
  assign unused_bits = ^{status[31:1], instr[10:6]};

  // Decode the incoming word and work out the next-state decisions for ARM and SETTLE.
  always_comb begin
    in_kind = decode(instr);
    in_trap = (in_kind == K_SYSCALL) || (in_kind == K_BREAK) ||
              ((in_kind == K_TEQ) && (rs_val == rt_val));

    cp0_write_req = (kind_q == K_ERET) || (kind_q == K_MTC0) ||
                    (kind_q == K_SYSCALL) || (kind_q == K_BREAK) ||
                    ((kind_q == K_TEQ) && eq_q);

    go_fire   = (state == S_ARM) && cp0_write_req && status[0];
    go_commit = ((state == S_ARM) && !go_fire) || (state == S_SETTLE);

    // Only a fired trap or eret reaches SETTLE with a redirect target from CP0.
    redirect  = (state == S_SETTLE) &&
                ((kind_q == K_SYSCALL) || (kind_q == K_BREAK) ||
                 (kind_q == K_TEQ) || (kind_q == K_ERET));
    commit_pc = redirect ? exc_addr : (pc_q + 32'(PC_STEP));
  end

  // Sequencer FSM with all outputs registered; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      kind_q        <= K_ILL;
      eq_q          <= 1'b0;
      pc_q          <= '0;
      rt_idx_q      <= '0;
      cp0_ena       <= 1'b0;
      cp0_mfc0      <= 1'b0;
      cp0_mtc0      <= 1'b0;
      cp0_exception <= 1'b0;
      cp0_eret      <= 1'b0;
      cp0_cause     <= '0;
      cp0_addr      <= '0;
      cp0_pc        <= '0;
      cp0_wdata     <= '0;
      pc_we         <= 1'b0;
      pc_wdata      <= '0;
      rf_we         <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      illegal       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_ARM;
            busy     <= 1'b1;
            kind_q   <= in_kind;
            eq_q     <= (rs_val == rt_val);
            pc_q     <= pc;
            rt_idx_q <= instr[20:16];
            // Commands go out during ARM so CP0 sees them stable before the strobe.
            if (in_kind != K_ILL) begin
              cp0_mfc0      <= (in_kind == K_MFC0);
              cp0_mtc0      <= (in_kind == K_MTC0);
              cp0_eret      <= (in_kind == K_ERET);
              cp0_exception <= in_trap;
              cp0_cause     <= cause_of(in_kind);
              cp0_addr      <= instr[15:11];
              cp0_pc        <= pc;
              cp0_wdata     <= rt_val;
            end
          end
        end
        S_ARM: begin
          if (go_fire) begin
            state   <= S_FIRE;
            cp0_ena <= 1'b1;
          end
        end
        S_FIRE: begin
          state   <= S_SETTLE;
          cp0_ena <= 1'b0;
        end
        S_SETTLE: begin
          // Commit entry below captures exc_addr as the redirect target.
        end
        S_COMMIT: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          illegal  <= 1'b0;
          pc_we    <= 1'b0;
          pc_wdata <= '0;
          rf_we    <= 1'b0;
          rf_waddr <= '0;
          rf_wdata <= '0;
          cp0_mfc0 <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // Shared entry into COMMIT from ARM (no write) or SETTLE (after a write).
      if (go_commit) begin
        state         <= S_COMMIT;
        done          <= 1'b1;
        illegal       <= (kind_q == K_ILL);
        pc_we         <= (kind_q != K_ILL);
        pc_wdata      <= (kind_q != K_ILL) ? commit_pc : 32'h0;
        rf_we         <= (kind_q == K_MFC0);
        rf_waddr      <= (kind_q == K_MFC0) ? rt_idx_q : 5'h0;
        rf_wdata      <= (kind_q == K_MFC0) ? cp0_rdata : 32'h0;
        cp0_mtc0      <= 1'b0;
        cp0_exception <= 1'b0;
        cp0_eret      <= 1'b0;
        cp0_cause     <= '0;
        cp0_addr      <= '0;
        cp0_pc        <= '0;
        cp0_wdata     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_trap_seq.sv
// Directed bench for trap_seq: each instruction class, status gating, reset and busy behaviour.
// Outputs are sampled 1ns after the rising edge; inputs change at the same point.
// Expected values are hand-computed constants.
module tb_trap_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] cp0_rdata;
  logic [31:0] exc_addr;
  logic [31:0] status;
  logic        cp0_ena;
  logic        cp0_mfc0;
  logic        cp0_mtc0;
  logic        cp0_exception;
  logic        cp0_eret;
  logic [4:0]  cp0_cause;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_pc;
  logic [31:0] cp0_wdata;
  logic        pc_we;
  logic [31:0] pc_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;
  logic        done;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  // Values captured by run_seq.
  int          lat;
  int          enas;
  logic        a_exc;
  logic        a_mfc0;
  logic        a_mtc0;
  logic        a_eret;
  logic [4:0]  a_cause;
  logic [31:0] a_wdata;
  logic        c_pc_we;
  logic [31:0] c_pc_wdata;
  logic        c_rf_we;
  logic [4:0]  c_rf_waddr;
  logic [31:0] c_rf_wdata;
  logic        c_illegal;
  logic        c_exc;

  trap_seq #(.PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .pc(pc),
    .rs_val(rs_val), .rt_val(rt_val), .cp0_rdata(cp0_rdata),
    .exc_addr(exc_addr), .status(status),
    .cp0_ena(cp0_ena), .cp0_mfc0(cp0_mfc0), .cp0_mtc0(cp0_mtc0),
    .cp0_exception(cp0_exception), .cp0_eret(cp0_eret),
    .cp0_cause(cp0_cause), .cp0_addr(cp0_addr), .cp0_pc(cp0_pc),
    .cp0_wdata(cp0_wdata), .pc_we(pc_we), .pc_wdata(pc_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .done(done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction with start for one edge; returns in the ARM cycle.
  task automatic launch(input logic [31:0] w, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b);
    instr  = w;
    pc     = p;
    rs_val = a;
    rt_val = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Launch, then follow the sequence to done (bounded) and back to IDLE.
  task automatic run_seq(input logic [31:0] w, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
    launch(w, p, a, b);
    lat  = 0;
    enas = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 1) begin
        a_exc   = cp0_exception;
        a_mfc0  = cp0_mfc0;
        a_mtc0  = cp0_mtc0;
        a_eret  = cp0_eret;
        a_cause = cp0_cause;
        a_wdata = cp0_wdata;
      end
      if (cp0_ena) enas++;
      if (done) begin
        lat        = c;
        c_pc_we    = pc_we;
        c_pc_wdata = pc_wdata;
        c_rf_we    = rf_we;
        c_rf_waddr = rf_waddr;
        c_rf_wdata = rf_wdata;
        c_illegal  = illegal;
        c_exc      = cp0_exception;
        break;
      end
      tick();
    end
    tick();
  endtask

  initial begin
    int ndone;
    int nena;
    int nill;
    rst       = 1'b1;
    start     = 1'b0;
    instr     = '0;
    pc        = '0;
    rs_val    = '0;
    rt_val    = '0;
    cp0_rdata = '0;
    exc_addr  = 32'h0040_0004;
    status    = 32'h0000_001F;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ena", cp0_ena, 0);
    check("rst_pc_we", pc_we, 0);
    rst = 1'b0;
    tick();

    // syscall, step by step
    launch(32'h0000_000C, 32'h0040_0020, 0, 0);
    check("sys_arm_busy", busy, 1);
    check("sys_arm_exc", cp0_exception, 1);
    check("sys_arm_cause", cp0_cause, 5'b01000);
    check("sys_arm_ena", cp0_ena, 0);
    check("sys_arm_pc", cp0_pc, 32'h0040_0020);
    tick();
    check("sys_fire_ena", cp0_ena, 1);
    check("sys_fire_exc", cp0_exception, 1);
    tick();
    check("sys_settle_ena", cp0_ena, 0);
    check("sys_settle_cause", cp0_cause, 5'b01000);
    check("sys_settle_done", done, 0);
    tick();
    check("sys_commit_done", done, 1);
    check("sys_commit_pc_we", pc_we, 1);
    check("sys_commit_pc", pc_wdata, 32'h0040_0004);
    check("sys_commit_exc", cp0_exception, 0);
    tick();
    check("sys_idle_busy", busy, 0);
    check("sys_idle_done", done, 0);

    // teq, operands differ: no trap
    run_seq(32'h0000_0034, 32'h0040_0100, 5, 6);
    check("teq_ne_lat", lat, 2);
    check("teq_ne_ena", enas, 0);
    check("teq_ne_pc", c_pc_wdata, 32'h0040_0104);
    check("teq_ne_pc_we", c_pc_we, 1);

    // teq, operands equal: trap and redirect
    exc_addr = 32'h8000_0180;
    run_seq(32'h0000_0034, 32'h0040_0200, 5, 5);
    check("teq_eq_lat", lat, 4);
    check("teq_eq_ena", enas, 1);
    check("teq_eq_cause", a_cause, 5'b01101);
    check("teq_eq_exc", a_exc, 1);
    check("teq_eq_pc", c_pc_wdata, 32'h8000_0180);

    // mfc0 $t0,$12
    cp0_rdata = 32'h0000_001F;
    run_seq(32'h4008_6000, 32'h0040_0300, 0, 0);
    check("mfc0_lat", lat, 2);
    check("mfc0_ena", enas, 0);
    check("mfc0_cmd", a_mfc0, 1);
    check("mfc0_rf_we", c_rf_we, 1);
    check("mfc0_waddr", c_rf_waddr, 8);
    check("mfc0_wdata", c_rf_wdata, 32'h0000_001F);
    check("mfc0_pc", c_pc_wdata, 32'h0040_0304);

    // mtc0 writes CP0 but does not redirect
    run_seq(32'h4088_6000, 32'h0040_0400, 0, 32'hDEAD_BEEF);
    check("mtc0_lat", lat, 4);
    check("mtc0_ena", enas, 1);
    check("mtc0_cmd", a_mtc0, 1);
    check("mtc0_wdata", a_wdata, 32'hDEAD_BEEF);
    check("mtc0_pc", c_pc_wdata, 32'h0040_0404);

    // eret redirects to exc_addr
    exc_addr = 32'h0040_1000;
    run_seq(32'h4200_0018, 32'h8000_0200, 0, 0);
    check("eret_lat", lat, 4);
    check("eret_cmd", a_eret, 1);
    check("eret_pc", c_pc_wdata, 32'h0040_1000);

    // break with status[0]=0: gated off
    status = 32'h0000_001E;
    run_seq(32'h0000_000D, 32'h0040_0500, 0, 0);
    check("brk_off_lat", lat, 2);
    check("brk_off_ena", enas, 0);
    check("brk_off_pc", c_pc_wdata, 32'h0040_0504);
    status = 32'h0000_001F;

    // illegal word
    run_seq(32'hFC00_0000, 32'h0040_0600, 0, 0);
    check("ill_lat", lat, 2);
    check("ill_flag", c_illegal, 1);
    check("ill_pc_we", c_pc_we, 0);
    check("ill_rf_we", c_rf_we, 0);
    check("ill_ena", enas, 0);

    // sequential PC wraps at 32 bits
    run_seq(32'h0000_0034, 32'hFFFF_FFFC, 1, 2);
    check("wrap_pc", c_pc_wdata, 32'h0000_0000);

    // reset during FIRE
    launch(32'h0000_000C, 32'h0040_0700, 0, 0);
    tick();
    check("rf_fire_ena", cp0_ena, 1);
    rst = 1'b1;
    #1;
    check("rf_rst_ena", cp0_ena, 0);
    check("rf_rst_busy", busy, 0);
    check("rf_rst_exc", cp0_exception, 0);
    tick();
    rst = 1'b0;
    ndone = 0;
    nena  = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) ndone++;
      if (cp0_ena) nena++;
      tick();
    end
    check("rf_no_done", ndone, 0);
    check("rf_no_ena", nena, 0);

    // first start after reset is accepted immediately
    run_seq(32'h0000_0034, 32'h0040_0800, 1, 2);
    check("post_rst_lat", lat, 2);
    check("post_rst_pc", c_pc_wdata, 32'h0040_0804);

    // second start while busy is dropped
    exc_addr = 32'h0040_2000;
    launch(32'h0000_0034, 32'h0040_0900, 7, 7);
    instr = 32'hFC00_0000;
    pc    = 32'h1234_5678;
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    nill  = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) begin
        ndone++;
        if (illegal) nill++;
        check("busy_pc", pc_wdata, 32'h0040_2000);
      end
      tick();
    end
    check("busy_one_done", ndone, 1);
    check("busy_no_ill", nill, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_seq.md
TRAP_SEQ -- requirements
Module: trap_seq

Interface
REQ-001 Parameter: PC_STEP, default 4, sequential-PC increment added to the latched pc.
REQ-002 clk  in  1  system clock; all state changes on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  one-cycle request from the multicycle controller to process instr; ignored while busy.
REQ-005 instr  in  32  instruction word, sampled when start is accepted.
REQ-006 pc  in  32  address of instr, sampled with instr.
REQ-007 rs_val, rt_val  in  32 each  register operands, sampled with instr.
REQ-008 cp0_rdata, exc_addr, status  in  32 each  CP0 read data, CP0 redirect address, CP0 status word.
REQ-009 cp0_ena, cp0_mfc0, cp0_mtc0, cp0_exception, cp0_eret  out  1 each  CP0 strobe and commands.
REQ-010 cp0_cause, cp0_addr  out  5 each  cause code and CP0 register index (instr[15:11]).
REQ-011 cp0_pc, cp0_wdata  out  32 each  latched pc and latched rt_val.
REQ-012 pc_we / pc_wdata  out  1 / 32  PC write strobe and new PC.
REQ-013 rf_we / rf_waddr / rf_wdata  out  1 / 5 / 32  register-file write for mfc0 (waddr = instr[20:16]).
REQ-014 busy, done, illegal  out  1 each  sequence active; one-cycle completion pulse; unrecognised instruction flag (valid with done).

Function
REQ-015 Decode of latched instr: syscall = op 0, funct 0x0C (cause 5'b01000); break = op 0, funct 0x0D (cause 5'b01001); teq = op 0, funct 0x34 (cause 5'b01101); eret = op 0x10, rs 0x10, funct 0x18; mfc0 = op 0x10, rs 0; mtc0 = op 0x10, rs 4; anything else is illegal.
REQ-016 States IDLE, ARM, FIRE, SETTLE, COMMIT; one state per clock; busy=1 in every state except IDLE.
REQ-017 IDLE: start=1 latches instr, pc, rs_val, rt_val and moves to ARM.
REQ-018 ARM: command outputs (mfc0/mtc0/exception/eret/cause/addr/pc/wdata) driven from latched values with cp0_ena=0; a CP0 write is needed for eret, mtc0, syscall, break, and teq with rs_val==rt_val, each only if status[0]=1 sampled in ARM; if needed go to FIRE, else go to COMMIT.
REQ-019 FIRE: cp0_ena=1 for exactly this one cycle, all commands unchanged.
REQ-020 SETTLE: cp0_ena=0, commands unchanged; exc_addr captured into an internal register at the end of this cycle.
REQ-021 COMMIT: done=1 for one cycle, all CP0 commands 0, then IDLE.
REQ-022 COMMIT PC: pc_we=1 for every recognised instruction; pc_wdata = captured exc_addr if FIRE occurred for syscall/break/teq/eret, otherwise latched pc + PC_STEP (32-bit wrap).
REQ-023 mfc0: cp0_mfc0 asserted from ARM through COMMIT; rf_we=1 in COMMIT with rf_wdata = cp0_rdata; no cp0_ena pulse.
REQ-024 illegal: in COMMIT illegal=1, pc_we=0, rf_we=0; no CP0 activity.
REQ-025 Latency: start to done = 4 cycles with a CP0 write, 2 cycles without.
REQ-026 start during busy: dropped, no queueing; no input other than start, rst, cp0_rdata, status and exc_addr affects an active sequence.
REQ-027 cp0_ena never high in two consecutive cycles; commands are never changed in the cycle cp0_ena is high or the cycle after.

Reset
REQ-028 rst=1 forces IDLE immediately; all outputs and latched registers become 0, including mid-sequence; a FIRE cycle cut by reset produces no further ena pulse.
REQ-029 After rst deasserts, the first accepted start is the first posedge with start=1.

Verification
REQ-030 syscall (0x0000000C), pc=0x00400020, status=0x1F, cp0 model returns exc_addr=0x00400004 -> cp0_exception=1, cause=01000 in ARM-SETTLE, one ena pulse at cycle 2, done at cycle 4, pc_wdata=0x00400004.
REQ-031 teq with rs_val=5, rt_val=6 -> no cp0_ena, done at cycle 2, pc_wdata=pc+4; repeat with rt_val=5 -> cause=01101, redirect to exc_addr.
REQ-032 mfc0 $t0,$12 (0x40086000), cp0_rdata=0x1F -> rf_we=1, rf_waddr=8, rf_wdata=0x1F, pc_wdata=pc+4, no ena.
REQ-033 status=0x1E with break -> no ena, done at cycle 2, pc_wdata=pc+4; illegal word 0xFC000000 -> illegal=1, pc_we=0.
REQ-034 rst asserted during FIRE -> cp0_ena=0 immediately, busy=0, no done; second start during busy -> ignored, single done observed.
